// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-word layout and field offsets.
package ctrl_pkg;

    localparam int unsigned CTRL_W = 21;

    localparam logic [6:0] OPC_R_M   = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam int unsigned ALUOP_OFF   = 19;
    localparam int unsigned ALUOP_W     = 2;
    localparam int unsigned ALUSRC_OFF  = 17;
    localparam int unsigned ALUSRC_W    = 2;
    localparam int unsigned JB_OFF      = 15;
    localparam int unsigned JB_W        = 2;
    localparam int unsigned BRTYPE_OFF  = 12;
    localparam int unsigned BRTYPE_W    = 3;
    localparam int unsigned MEMRD_OFF   = 11;
    localparam int unsigned LDTYPE_OFF  = 8;
    localparam int unsigned LDTYPE_W    = 3;
    localparam int unsigned MEMWR_OFF   = 7;
    localparam int unsigned STTYPE_OFF  = 4;
    localparam int unsigned STTYPE_W    = 3;
    localparam int unsigned INST_OFF    = 2;
    localparam int unsigned INST_W      = 2;
    localparam int unsigned REGWR_OFF   = 1;
    localparam int unsigned MEM2REG_OFF = 0;

    // Field order matches the packed control word, MSB first.
    typedef struct packed {
        logic [ALUOP_W-1:0]  alu_op;
        logic [ALUSRC_W-1:0] alu_src;
        logic [JB_W-1:0]     jump_branch;
        logic [BRTYPE_W-1:0] branch_type;
        logic                mem_read;
        logic [LDTYPE_W-1:0] load_type;
        logic                mem_write;
        logic [STTYPE_W-1:0] store_type;
        logic [INST_W-1:0]   inst_type;
        logic                reg_write;
        logic                memto_reg;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational RV32I/M control decoder: control word, illegal flag and source-register usage.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_M = 1
) (
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              use_rs1,
    output logic              use_rs2
);

    ctrl_t      c;
    logic [2:0] f3;
    logic       is_m;

    assign f3   = inst[14:12];
    assign is_m = inst[25];

    // Register indices and immediates are extracted by the stage, not here.
    logic unused_inst;
    assign unused_inst = ^{inst[31:26], inst[24:15], inst[11:7]};

    always_comb begin
        c       = '0;
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            OPC_R_M: begin
                if (is_m && (EN_M == 0)) begin
                    illegal = 1'b1;
                end else begin
                    c.alu_op    = is_m ? 2'b11 : 2'b10;
                    c.reg_write = 1'b1;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
            end
            OPC_I: begin
                c.alu_op    = 2'b10;
                c.alu_src   = 2'b01;
                c.reg_write = 1'b1;
                use_rs1     = 1'b1;
            end
            OPC_L: begin
                c.alu_src   = 2'b01;
                c.mem_read  = 1'b1;
                c.load_type = f3;
                c.reg_write = 1'b1;
                c.memto_reg = 1'b1;
                use_rs1     = 1'b1;
            end
            OPC_S: begin
                c.alu_src    = 2'b01;
                c.mem_write  = 1'b1;
                c.store_type = f3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OPC_JAL: begin
                c.alu_src     = 2'b11;
                c.jump_branch = 2'b10;
                c.inst_type   = 2'b10;
                c.reg_write   = 1'b1;
            end
            OPC_JALR: begin
                c.alu_src     = 2'b01;
                c.jump_branch = 2'b10;
                c.inst_type   = 2'b11;
                c.reg_write   = 1'b1;
                use_rs1       = 1'b1;
            end
            OPC_B: begin
                c.alu_op      = 2'b01;
                c.jump_branch = 2'b01;
                c.branch_type = f3;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_LUI: begin
                c.alu_src   = 2'b11;
                c.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                c.alu_src   = 2'b11;
                c.inst_type = 2'b01;
                c.reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use bubbling, flush and bubble counter.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned EN_M  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              dec_use_rs1;
    logic              dec_use_rs2;

    ctrl_decode_comb #(
        .EN_M(EN_M)
    ) u_decode (
        .inst    (in_inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2)
    );

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ill_q, ill_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0] held_rd;
    logic       hazard;
    logic       adv;
    logic       accept;
    logic       bubble;

    assign held_rd = inst_q[11:7];

    // A held load whose destination feeds the incoming instruction must be stalled one cycle.
    assign hazard = valid_q && ctrl_q[MEMRD_OFF] && (held_rd != 5'd0) &&
                    ((dec_use_rs1 && (in_inst[19:15] == held_rd)) ||
                     (dec_use_rs2 && (in_inst[24:20] == held_rd)));

    assign adv      = !valid_q || out_ready;
    assign in_ready = adv && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign bubble   = adv && in_valid && hazard && !flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            ill_d   = dec_illegal;
            inst_d  = in_inst;
            pc_d    = in_pc;
        end else if (adv) begin
            valid_d = 1'b0;
        end
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_ctrl    = ctrl_q;
    assign out_illegal = ill_q;
    assign out_inst    = inst_q;
    assign out_pc      = pc_q;
    assign out_rs1     = inst_q[19:15];
    assign out_rs2     = inst_q[24:20];
    assign out_rd      = held_rd;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_ctrl_decode_stage;

    localparam logic [31:0] ADD  = 32'h00228333;
    localparam logic [31:0] MUL  = 32'h020083B3;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] ADDI = 32'h00100193;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [20:0] out_ctrl;
    logic [31:0] out_inst, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [15:0] bubble_cnt;

    logic [20:0] nm_ctrl;
    logic        nm_illegal;
    logic [1:0]  c2_cnt;

    logic        nm_unused_rdy, nm_unused_vld;
    logic [31:0] nm_unused_inst, nm_unused_pc;
    logic [4:0]  nm_unused_rs1, nm_unused_rs2, nm_unused_rd;
    logic [15:0] nm_unused_cnt;
    logic        c2_unused_rdy, c2_unused_vld, c2_unused_ill;
    logic [20:0] c2_unused_ctrl;
    logic [31:0] c2_unused_inst, c2_unused_pc;
    logic [4:0]  c2_unused_rs1, c2_unused_rs2, c2_unused_rd;

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] opcs [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1101111,
                             7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

    always #5 clk = ~clk;

    ctrl_decode_stage #(.XLEN(32), .EN_M(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .bubble_cnt(bubble_cnt)
    );

    ctrl_decode_stage #(.XLEN(32), .EN_M(0), .CNT_W(16)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_unused_rdy),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(nm_unused_vld), .out_ready(out_ready),
        .out_ctrl(nm_ctrl), .out_illegal(nm_illegal), .out_inst(nm_unused_inst),
        .out_pc(nm_unused_pc), .out_rs1(nm_unused_rs1), .out_rs2(nm_unused_rs2),
        .out_rd(nm_unused_rd), .bubble_cnt(nm_unused_cnt)
    );

    ctrl_decode_stage #(.XLEN(32), .EN_M(1), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c2_unused_rdy),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(c2_unused_vld), .out_ready(out_ready),
        .out_ctrl(c2_unused_ctrl), .out_illegal(c2_unused_ill), .out_inst(c2_unused_inst),
        .out_pc(c2_unused_pc), .out_rs1(c2_unused_rs1), .out_rs2(c2_unused_rs2),
        .out_rd(c2_unused_rd), .bubble_cnt(c2_cnt)
    );

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_inst   = i;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        edge_wait();
    endtask

    // Reference decode straight from the opcode table (EN_M=1 flavour).
    function automatic void ref_decode(input logic [31:0] i, output logic [20:0] c,
                                       output logic ill, output logic u1, output logic u2);
        logic [2:0] f = i[14:12];
        ill = 1'b0;
        case (i[6:0])
            7'b0110011: begin
                c = {(i[25] ? 2'b11 : 2'b10), 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0,
                     3'b000, 2'b00, 1'b1, 1'b0};
                u1 = 1; u2 = 1;
            end
            7'b0010011: begin
                c = {2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
                u1 = 1; u2 = 0;
            end
            7'b0000011: begin
                c = {2'b00, 2'b01, 2'b00, 3'b000, 1'b1, f, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1};
                u1 = 1; u2 = 0;
            end
            7'b0100011: begin
                c = {2'b00, 2'b01, 2'b00, 3'b000, 1'b0, 3'b000, 1'b1, f, 2'b00, 1'b0, 1'b0};
                u1 = 1; u2 = 1;
            end
            7'b1101111: begin
                c = {2'b00, 2'b11, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 2'b10, 1'b1, 1'b0};
                u1 = 0; u2 = 0;
            end
            7'b1100111: begin
                c = {2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 2'b11, 1'b1, 1'b0};
                u1 = 1; u2 = 0;
            end
            7'b1100011: begin
                c = {2'b01, 2'b00, 2'b01, f, 1'b0, 3'b000, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
                u1 = 1; u2 = 1;
            end
            7'b0110111: begin
                c = {2'b00, 2'b11, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0};
                u1 = 0; u2 = 0;
            end
            7'b0010111: begin
                c = {2'b00, 2'b11, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0};
                u1 = 0; u2 = 0;
            end
            default: begin
                c = '0; ill = 1'b1; u1 = 0; u2 = 0;
            end
        endcase
    endfunction

    task automatic test_reset();
        n_total++;
        if ({out_valid, out_ctrl, out_illegal} !== 23'h0)
            $display("FAIL reset_ctrl: got %h required 0", {out_valid, out_ctrl, out_illegal});
        else n_pass++;
        n_total++;
        if ({out_inst, out_pc, out_rs1, out_rs2, out_rd, bubble_cnt} !== 95'h0)
            $display("FAIL reset_data: got %h/%h cnt %h required 0", out_inst, out_pc, bubble_cnt);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        drive(1'b1, ADD, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b required 1", in_ready);
        else n_pass++;
        edge_wait();
        n_total++;
        if ({out_valid, out_ctrl, out_illegal} !== {1'b1, 21'h100002, 1'b0})
            $display("FAIL basic_ctrl: got %b %h %b required 1 100002 0",
                     out_valid, out_ctrl, out_illegal);
        else n_pass++;
        n_total++;
        if ({out_rs1, out_rs2, out_rd, out_pc, out_inst} !== {5'd5, 5'd2, 5'd6, 32'h100, ADD})
            $display("FAIL basic_fields: got rs1 %0d rs2 %0d rd %0d pc %h inst %h required 5 2 6 100 %h",
                     out_rs1, out_rs2, out_rd, out_pc, out_inst, ADD);
        else n_pass++;
        drain();
    endtask

    task automatic test_mul();
        drive(1'b1, MUL, 32'h180, 1'b1, 1'b0);
        edge_wait();
        n_total++;
        if ({out_ctrl, out_illegal} !== {21'h180002, 1'b0})
            $display("FAIL mul_en: got %h %b required 180002 0", out_ctrl, out_illegal);
        else n_pass++;
        n_total++;
        if ({nm_ctrl, nm_illegal} !== {21'h0, 1'b1})
            $display("FAIL mul_dis: got %h %b required 0 1", nm_ctrl, nm_illegal);
        else n_pass++;
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, LW, 32'h200, 1'b1, 1'b0);
        edge_wait();
        n_total++;
        if ({out_valid, out_ctrl} !== {1'b1, 21'h020A03})
            $display("FAIL lw_ctrl: got %b %h required 1 020a03", out_valid, out_ctrl);
        else n_pass++;
        drive(1'b1, ADD, 32'h204, 1'b1, 1'b0);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL lu_stall: got %b required 0", in_ready);
        else n_pass++;
        edge_wait();
        n_total++;
        if ({out_valid, bubble_cnt} !== {1'b0, 16'd1})
            $display("FAIL lu_bubble: got valid %b cnt %0d required 0 1", out_valid, bubble_cnt);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL lu_resume: got %b required 1", in_ready);
        else n_pass++;
        edge_wait();
        n_total++;
        if ({out_valid, out_pc, out_ctrl} !== {1'b1, 32'h204, 21'h100002})
            $display("FAIL lu_accept: got %b %h %h required 1 204 100002",
                     out_valid, out_pc, out_ctrl);
        else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        drive(1'b1, ADD, 32'h300, 1'b1, 1'b0);
        edge_wait();
        drive(1'b1, ADDI, 32'h304, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready: got %b required 0", in_ready);
            else n_pass++;
            edge_wait();
            n_total++;
            if ({out_valid, out_pc, out_inst, out_ctrl} !== {1'b1, 32'h300, ADD, 21'h100002})
                $display("FAIL bp_hold: got %b %h %h %h required 1 300 %h 100002",
                         out_valid, out_pc, out_inst, out_ctrl, ADD);
            else n_pass++;
        end
        drive(1'b1, ADDI, 32'h304, 1'b1, 1'b0);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release: got %b required 1", in_ready);
        else n_pass++;
        edge_wait();
        n_total++;
        if ({out_valid, out_pc, out_rd, out_ctrl} !== {1'b1, 32'h304, 5'd3, 21'h120002})
            $display("FAIL bp_next: got %b %h %0d %h required 1 304 3 120002",
                     out_valid, out_pc, out_rd, out_ctrl);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, LW, 32'h400, 1'b1, 1'b0);
        edge_wait();
        drive(1'b1, ADD, 32'h404, 1'b1, 1'b1);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b required 0", in_ready);
        else n_pass++;
        edge_wait();
        n_total++;
        if ({out_valid, bubble_cnt} !== {1'b0, 16'd1})
            $display("FAIL flush_kill: got valid %b cnt %0d required 0 1", out_valid, bubble_cnt);
        else n_pass++;
        drain();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_noaccept: got %b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, LW, 32'h600, 1'b1, 1'b0);
            edge_wait();
            drive(1'b1, ADD, 32'h604, 1'b1, 1'b0);
            edge_wait();
        end
        n_total++;
        if (c2_cnt !== 2'd3) $display("FAIL sat_c2: got %0d required 3", c2_cnt);
        else n_pass++;
        n_total++;
        if (bubble_cnt !== 16'd6) $display("FAIL sat_c16: got %0d required 6", bubble_cnt);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, ADD, 32'h500, 1'b1, 1'b0);
        edge_wait();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, out_ctrl, out_inst, out_pc, out_rd, bubble_cnt, c2_cnt} !== 109'h0)
            $display("FAIL mid_reset: got %b %h %h %h cnt %0d/%0d required all 0",
                     out_valid, out_ctrl, out_inst, out_pc, bubble_cnt, c2_cnt);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b required 1", in_ready);
        else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        m_valid = 1'b0, m_ill = 1'b0;
        logic [20:0] m_ctrl = '0;
        logic [31:0] m_inst = '0, m_pc = '0;
        int          m_cnt = 0, m_cnt2 = 0;
        logic [20:0] dc;
        logic        dill, du1, du2, haz, adv, exp_rdy;
        logic [4:0]  hrd;
        logic [31:0] ri;
        edge_wait();
        for (int k = 0; k < 400; k++) begin
            ri = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom), 5'($urandom_range(0, 3)), opcs[$urandom_range(0, 8)]};
            drive(($urandom_range(0, 3) != 0), ri, $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            ref_decode(in_inst, dc, dill, du1, du2);
            hrd = m_inst[11:7];
            haz = m_valid && (m_inst[6:0] == 7'b0000011) && (hrd != 5'd0) &&
                  ((du1 && in_inst[19:15] == hrd) || (du2 && in_inst[24:20] == hrd));
            adv = !m_valid || out_ready;
            exp_rdy = adv && !haz && !flush;
            @(negedge clk);
            n_total++;
            if (in_ready !== exp_rdy)
                $display("FAIL rnd_ready[%0d]: got %b required %b", k, in_ready, exp_rdy);
            else n_pass++;
            @(posedge clk);
            if (adv && in_valid && haz && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_rdy) begin
                m_valid = 1'b1; m_ctrl = dc; m_ill = dill; m_inst = in_inst; m_pc = in_pc;
            end else if (adv) m_valid = 1'b0;
            #1;
            n_total++;
            if ({out_valid, out_ctrl, out_illegal, out_inst, out_pc} !==
                {m_valid, m_ctrl, m_ill, m_inst, m_pc})
                $display("FAIL rnd_out[%0d]: got %b %h %b %h %h required %b %h %b %h %h", k,
                         out_valid, out_ctrl, out_illegal, out_inst, out_pc,
                         m_valid, m_ctrl, m_ill, m_inst, m_pc);
            else n_pass++;
            n_total++;
            if ({out_rs1, out_rs2, out_rd, bubble_cnt, c2_cnt} !==
                {m_inst[19:15], m_inst[24:20], m_inst[11:7], 16'(m_cnt), 2'(m_cnt2)})
                $display("FAIL rnd_regs[%0d]: got %0d %0d %0d cnt %0d/%0d required %0d %0d %0d %0d/%0d",
                         k, out_rs1, out_rs2, out_rd, bubble_cnt, c2_cnt,
                         m_inst[19:15], m_inst[24:20], m_inst[11:7], m_cnt, m_cnt2);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #12;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_mul();
        test_load_use();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered instruction-decode stage for the RV32I/M core.
- Decodes the 21-bit control word and register indices from a fetched instruction, then holds them in an ID/EX pipeline register.
- Uses a valid/ready handshake on both sides.
- Adds load-use hazard bubbling, flush, illegal-instruction flagging, an optional M-extension, and a saturating bubble counter.

Parameters:
- XLEN, 32, PC width.
- EN_M, 1, when 1, R-type with funct7[0]=1 decodes as M-extension; when 0, it is illegal.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  kill the held and incoming instruction (branch/jump redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  PC of in_inst.
- out_valid  output  1  ID/EX register holds a valid instruction.
- out_ready  input  1  EX consumes the held instruction.
- out_ctrl  output  21  control word.
- out_illegal  output  1  held instruction is illegal.
- out_inst  output  32  held instruction word.
- out_pc  output  XLEN  held PC.
- out_rs1, out_rs2, out_rd  output  5 each  inst[19:15], inst[24:20], inst[11:7].
- bubble_cnt  output  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Control word fields, MSB to LSB (21 bits):
  - ALUOp[20:19], ALUSrc[18:17], JumpBranch[16:15], BranchType[14:12]
  - MemRead[11], LoadType[10:8], MemWrite[7], StoreType[6:4]
  - Inst[3:2], RegWrite[1], MemtoReg[0]
- Decode table (field order as above; f3 = funct3):
  - R, funct7[0]=0: 10,00,00,000,0,000,0,000,00,1,0
  - R, funct7[0]=1 (requires EN_M=1): 11, remaining fields as R
  - I-ALU (0010011): 10,01,00,000,0,000,0,000,00,1,0
  - LOAD: 00,01,00,000,1,f3,0,000,00,1,1
  - STORE: 00,01,00,000,0,000,1,f3,00,0,0
  - JAL: 00,11,10,000,0,000,0,000,10,1,0
  - JALR: 00,01,10,000,0,000,0,000,11,1,0
  - BRANCH: 01,00,01,f3,0,000,0,000,00,0,0
  - LUI: 00,11,00,000,0,000,0,000,00,1,0
  - AUIPC: 00,11,00,000,0,000,0,000,01,1,0
- Illegal instructions:
  - Cases: unknown opcode, or M-encoding with EN_M=0.
  - Control word is all zero; out_illegal=1.
  - An illegal instruction still flows through the handshake normally.
- Source usage:
  - R, STORE, BRANCH use rs1 and rs2.
  - I-ALU, LOAD, JALR use rs1 only.
  - JAL, LUI, AUIPC use no sources.
- Load-use hazard, evaluated combinationally. All of the following must hold:
  - out_valid=1 and out_ctrl[11]=1;
  - out_rd≠0;
  - the incoming instruction uses a source equal to out_rd.
- Handshake:
  - adv = !out_valid | out_ready
  - in_ready = adv & !hazard & !flush
  - When in_valid & in_ready, all out_* registers load on the next edge, out_valid=1. Latency is 1 cycle.
  - adv & !(in_valid & in_ready): out_valid←0. This is a bubble when caused by hazard.
  - !adv: all outputs hold, stable under backpressure.
- Flush has highest priority:
  - out_valid←0 next edge.
  - The incoming instruction is not accepted (in_ready=0).
  - The bubble counter is not incremented.
- bubble_cnt increments when adv & in_valid & hazard & !flush, and saturates at all-ones.
- Reset (asynchronous, rst_n=0): out_valid=0, out_ctrl=0, out_illegal=0, out_inst=0, out_pc=0, out_rs*/out_rd=0, bubble_cnt=0.
  - Reset mid-operation discards the held instruction.
  - in_ready follows from out_valid=0 during reset.
- A hazard lasts at most one cycle: after the bubble, out_valid=0, which clears the hazard.

Decomposition:
- Package ctrl_pkg contains:
  - opcode constants (R_M, I, L, S, JAL, JALR, B, LUI, AUIPC);
  - control-field bit offsets and widths;
  - CTRL_W=21.
- One combinational sub-module, ctrl_decode_comb, parametrised by EN_M.
  - Inputs: inst.
  - Outputs: ctrl, illegal, use_rs1, use_rs2.
- ctrl_decode_stage holds the pipeline register, hazard logic and counter.

Test Plan:
- Basic decode: add x6,x5,x2 (0x00228333), out_ready=1 → next cycle out_valid=1, out_ctrl=0x100002, rs1=5, rs2=2, rd=6.
- M-extension: mul x7,x1,x2 (0x020083B3).
  - EN_M=1 → out_ctrl=0x180002, out_illegal=0.
  - EN_M=0 → out_ctrl=0, out_illegal=1.
- Load-use: lw x5,0(x1) (0x0000A283; out_ctrl=0x020A03) followed by 0x00228333 →
  - one cycle with in_ready=0 and a bubble (out_valid=0);
  - add is accepted on the next cycle;
  - bubble_cnt=1.
- Backpressure: hold out_ready=0 for 3 cycles with a valid instruction held → outputs stable, in_ready=0; release → next instruction loads.
- Flush: assert flush while holding lw with in_valid=1 → out_valid=0 next cycle, incoming not accepted, bubble_cnt unchanged.
- Reset and saturation:
  - CNT_W=2, force 5 hazards → bubble_cnt=3.
  - Assert rst_n=0 mid-stream → all outputs 0 immediately.
